// File: rtl/covariance_sequencer.sv
// Gathers per-stock price ticks into sample vectors, feeds the covariance unit one window at a time,
// and holds each captured matrix behind a valid/ready handshake. Optional stale fill: COV_SEQ_STALE_EN.
module covariance_sequencer #(
   parameter int unsigned N_STOCKS     = 2,
   parameter int unsigned WINDOW       = 6,
   parameter int unsigned TIMEOUT      = 64,
   parameter int unsigned STALE_CYCLES = 16,
   localparam int unsigned IW          = (N_STOCKS > 1) ? $clog2(N_STOCKS) : 1
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             run,
   input  logic                             tick_valid,
   output logic                             tick_ready,
   input  logic [IW-1:0]                    tick_stock,
   input  logic [15:0]                      tick_price,
   output logic                             cov_rst,
   output logic                             cov_valid_in,
   output logic [N_STOCKS*16-1:0]           cov_x,
   input  logic                             cov_valid_out,
   input  logic [N_STOCKS*N_STOCKS*16-1:0]  cov_in,
   output logic                             res_valid,
   input  logic                             res_ready,
   output logic [N_STOCKS*N_STOCKS*16-1:0]  res_cov,
   output logic                             err_timeout
);

   localparam int unsigned PW = 16;
   localparam int unsigned MW = N_STOCKS * N_STOCKS * PW;
   localparam int unsigned CW = $clog2(WINDOW + 1);
   localparam int unsigned TW = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_GATHER, S_ISSUE, S_DRAIN, S_HOLD, S_CLEAR
   } state_t;

   state_t                       state_q, state_d;
   logic [N_STOCKS-1:0][PW-1:0]  slot_q, slot_d;
   logic [N_STOCKS-1:0]          mask_q, mask_d;
   logic [CW-1:0]                cnt_q, cnt_d;
   logic [TW-1:0]                drain_q, drain_d;
   logic [MW-1:0]                res_cov_q, res_cov_d;
   logic                         err_q, err_d;
   logic                         tick_ready_q, tick_ready_d;
   logic                         cov_valid_in_q, cov_valid_in_d;
   logic                         cov_rst_q, cov_rst_d;
   logic                         res_valid_q, res_valid_d;
   logic                         stock_ok;

`ifdef COV_SEQ_STALE_EN
   localparam int unsigned AW = $clog2(STALE_CYCLES + 1);
   logic [AW-1:0]                age_q, age_d;
`endif

   assign stock_ok = 32'(tick_stock) < N_STOCKS;

   // Next-state, datapath updates and registered-output precompute
   always_comb begin
      state_d   = state_q;
      slot_d    = slot_q;
      mask_d    = mask_q;
      cnt_d     = cnt_q;
      drain_d   = drain_q;
      res_cov_d = res_cov_q;
      err_d     = err_q;
`ifdef COV_SEQ_STALE_EN
      age_d     = age_q;
`endif
      unique case (state_q)
         S_IDLE: begin
            if (run) state_d = S_GATHER;
         end
         S_GATHER: begin
            if (tick_valid && stock_ok) begin
               slot_d[tick_stock] = tick_price;
               mask_d[tick_stock] = 1'b1;
            end
`ifdef COV_SEQ_STALE_EN
            // Age runs only once a vector has started collecting ticks
            if (mask_q != '0) age_d = age_q + AW'(1);
            if (&mask_d) state_d = S_ISSUE;
            else if (mask_q != '0 && age_q == AW'(STALE_CYCLES - 1)) state_d = S_ISSUE;
`else
            if (&mask_d) state_d = S_ISSUE;
`endif
         end
         S_ISSUE: begin
            mask_d  = '0;
            cnt_d   = cnt_q + CW'(1);
            drain_d = '0;
`ifdef COV_SEQ_STALE_EN
            age_d   = '0;
`endif
            state_d = (cnt_q == CW'(WINDOW - 1)) ? S_DRAIN : S_GATHER;
         end
         S_DRAIN: begin
            // First DRAIN cycle may still carry the previous result, so skip it
            if (drain_q != '0 && cov_valid_out) begin
               res_cov_d = cov_in;
               state_d   = S_HOLD;
            end else if (drain_q == TW'(TIMEOUT - 1)) begin
               err_d   = 1'b1;
               state_d = S_CLEAR;
            end else begin
               drain_d = drain_q + TW'(1);
            end
         end
         S_HOLD: begin
            if (res_ready) state_d = S_CLEAR;
         end
         S_CLEAR: begin
            cnt_d   = '0;
            mask_d  = '0;
`ifdef COV_SEQ_STALE_EN
            age_d   = '0;
`endif
            state_d = run ? S_GATHER : S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
      tick_ready_d   = (state_d == S_GATHER);
      cov_valid_in_d = (state_d == S_ISSUE);
      cov_rst_d      = (state_d == S_IDLE) || (state_d == S_CLEAR);
      res_valid_d    = (state_d == S_HOLD);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         slot_q         <= '0;
         mask_q         <= '0;
         cnt_q          <= '0;
         drain_q        <= '0;
         res_cov_q      <= '0;
         err_q          <= 1'b0;
         tick_ready_q   <= 1'b0;
         cov_valid_in_q <= 1'b0;
         cov_rst_q      <= 1'b1;
         res_valid_q    <= 1'b0;
`ifdef COV_SEQ_STALE_EN
         age_q          <= '0;
`endif
      end else begin
         state_q        <= state_d;
         slot_q         <= slot_d;
         mask_q         <= mask_d;
         cnt_q          <= cnt_d;
         drain_q        <= drain_d;
         res_cov_q      <= res_cov_d;
         err_q          <= err_d;
         tick_ready_q   <= tick_ready_d;
         cov_valid_in_q <= cov_valid_in_d;
         cov_rst_q      <= cov_rst_d;
         res_valid_q    <= res_valid_d;
`ifdef COV_SEQ_STALE_EN
         age_q          <= age_d;
`endif
      end
   end

   assign tick_ready   = tick_ready_q;
   assign cov_valid_in = cov_valid_in_q;
   assign cov_rst      = cov_rst_q;
   assign cov_x        = slot_q;
   assign res_valid    = res_valid_q;
   assign res_cov      = res_cov_q;
   assign err_timeout  = err_q;

endmodule

// File: tb/tb_covariance_sequencer.sv
// Randomized self-checking bench for covariance_sequencer (N_STOCKS=2, WINDOW=6, TIMEOUT=64).
// Reference model tracks slots/mask as plain arrays and queues the vectors it expects to see issued.
module tb_covariance_sequencer;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        run = 1'b0;
   logic        tick_valid = 1'b0;
   logic        tick_ready;
   logic [0:0]  tick_stock = '0;
   logic [15:0] tick_price = '0;
   logic        cov_rst;
   logic        cov_valid_in;
   logic [31:0] cov_x;
   logic        cov_valid_out = 1'b0;
   logic [63:0] cov_in = '0;
   logic        res_valid;
   logic        res_ready = 1'b0;
   logic [63:0] res_cov;
   logic        err_timeout;

   covariance_sequencer #(.N_STOCKS(2), .WINDOW(6), .TIMEOUT(64), .STALE_CYCLES(16)) dut (
      .clk(clk), .rst(rst), .run(run),
      .tick_valid(tick_valid), .tick_ready(tick_ready), .tick_stock(tick_stock),
      .tick_price(tick_price), .cov_rst(cov_rst), .cov_valid_in(cov_valid_in), .cov_x(cov_x),
      .cov_valid_out(cov_valid_out), .cov_in(cov_in), .res_valid(res_valid),
      .res_ready(res_ready), .res_cov(res_cov), .err_timeout(err_timeout)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;
   int n_issue = 0;
   logic prev_vin = 1'b0;
   logic res_seen = 1'b0;

   // Reference model state
   logic [15:0] m_slot [2];
   logic [1:0]  m_mask;
   logic [31:0] exp_q [$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_slot[0] = '0;
      m_slot[1] = '0;
      m_mask    = '0;
      exp_q.delete();
   endtask

   task automatic model_accept(input int s, input logic [15:0] p);
      if (s < 2) begin
         m_slot[s]  = p;
         m_mask[s]  = 1'b1;
         if (m_mask == 2'b11) begin
            exp_q.push_back({m_slot[1], m_slot[0]});
            m_mask = '0;
         end
      end
   endtask

   // Every issued vector must match the model and be a lone pulse
   always @(negedge clk) begin
      logic [31:0] e;
      if (!rst && cov_valid_in) begin
         if (exp_q.size() == 0) check("unexpected_issue", 64'(cov_x), 64'hdead);
         else begin
            e = exp_q.pop_front();
            check("cov_x", 64'(cov_x), 64'(e));
         end
         check("vin_single_pulse", 64'(prev_vin), 64'd0);
         n_issue++;
      end
      if (res_valid) res_seen = 1'b1;
      prev_vin = cov_valid_in;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send_tick(input int s, input logic [15:0] p);
      int n = 0;
      tick_valid = 1'b1;
      tick_stock = 1'(s);
      tick_price = p;
      while (!tick_ready && n < 100) begin
         step();
         n++;
      end
      if (!tick_ready) check("tick_ready_wait", 64'(tick_ready), 64'd1);
      model_accept(s, p);
      step();
      tick_valid = 1'b0;
   endtask

   // One complete vector in random order, optionally preceded by an overwritten tick
   task automatic send_vector(input logic [15:0] p0, input logic [15:0] p1);
      int first = int'($urandom_range(0, 1));
      if ($urandom_range(0, 1) == 1) send_tick(first, 16'($urandom));
      send_tick(first, first == 1 ? p1 : p0);
      send_tick(1 - first, first == 1 ? p0 : p1);
      check("issue_latency", 64'(cov_valid_in), 64'd1);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      model_reset();
      rst = 1'b0;
   endtask

   // Drive a result from the covariance unit, check capture, hold, and handshake
   task automatic finish_window(input logic [63:0] m, input int hold);
      int n = 0;
      cov_valid_out = 1'b1;
      cov_in = m;
      while (!res_valid && n < 20) begin
         step();
         n++;
      end
      check("res_valid", 64'(res_valid), 64'd1);
      check("res_cov", res_cov, m);
      cov_valid_out = 1'b0;
      cov_in = 64'($urandom);
      for (int i = 0; i < hold; i++) begin
         step();
         check("res_hold_valid", 64'(res_valid), 64'd1);
         check("res_hold_stable", res_cov, m);
      end
      res_ready = 1'b1;
      step();
      res_ready = 1'b0;
      check("res_valid_drop", 64'(res_valid), 64'd0);
      check("clear_cov_rst", 64'(cov_rst), 64'd1);
      step();
      check("clear_one_cycle", 64'(cov_rst), 64'd0);
      check("gather_resume", 64'(tick_ready), 64'd1);
   endtask

   initial begin
      int n;
      int base;
      logic [63:0] m;
      logic [15:0] p;
      model_reset();

      // 1: reset and IDLE
      do_reset();
      rst = 1'b1;
      check("rst_cov_rst", 64'(cov_rst), 64'd1);
      check("rst_res_valid", 64'(res_valid), 64'd0);
      check("rst_tick_ready", 64'(tick_ready), 64'd0);
      check("rst_err", 64'(err_timeout), 64'd0);
      check("rst_cov_x", 64'(cov_x), 64'd0);
      rst = 1'b0;
      step();
      check("idle_cov_rst", 64'(cov_rst), 64'd1);
      check("idle_tick_ready", 64'(tick_ready), 64'd0);
      run = 1'b1;
      step();
      check("run_tick_ready", 64'(tick_ready), 64'd1);
      check("run_cov_rst", 64'(cov_rst), 64'd0);

      // 2: gather, ordering and latest-wins overwrite
      send_tick(1, 16'h0300);
      send_tick(0, 16'h0100);
      check("g1_latency", 64'(cov_valid_in), 64'd1);
      check("g1_cov_x", 64'(cov_x), 64'h0300_0100);
      send_tick(0, 16'h0100);
      send_tick(0, 16'h0200);
      send_tick(1, 16'h0300);
      check("g2_cov_x", 64'(cov_x), 64'h0300_0200);

      // 3: full window with captured matrix and held result
      do_reset();
      for (int i = 0; i < 6; i++) begin
         send_vector(16'(i << 8), 16'h0300);
         if (i < 5) begin
            step();
            check("mid_window_ready", 64'(tick_ready), 64'd1);
         end
      end
      step();
      check("drain_no_ready", 64'(tick_ready), 64'd0);
      finish_window(64'd1249, 5);

      // 4: timeout with no result from the unit
      res_seen = 1'b0;
      for (int i = 0; i < 6; i++) send_vector(16'($urandom), 16'($urandom));
      n = 0;
      while (!err_timeout && n < 200) begin
         step();
         n++;
      end
      check("timeout_cycles", 64'(n), 64'd65);
      check("timeout_err", 64'(err_timeout), 64'd1);
      check("timeout_clear", 64'(cov_rst), 64'd1);
      check("timeout_no_res", 64'(res_seen), 64'd0);
      step();
      check("timeout_resume", 64'(tick_ready), 64'd1);
      check("timeout_sticky", 64'(err_timeout), 64'd1);

      // 5: abort mid-window, then a fresh six-sample window
      for (int i = 0; i < 3; i++) send_vector(16'($urandom), 16'($urandom));
      send_tick(0, 16'($urandom));
      rst = 1'b1;
      step();
      model_reset();
      check("abort_cov_rst", 64'(cov_rst), 64'd1);
      check("abort_ready", 64'(tick_ready), 64'd0);
      check("abort_vin", 64'(cov_valid_in), 64'd0);
      check("abort_err", 64'(err_timeout), 64'd0);
      check("abort_cov_x", 64'(cov_x), 64'd0);
      rst = 1'b0;
      base = n_issue;
      for (int i = 0; i < 6; i++) begin
         send_vector(16'($urandom), 16'($urandom));
         step();
         check("fresh_ready", 64'(tick_ready), (i < 5) ? 64'd1 : 64'd0);
      end
      check("fresh_count", 64'(n_issue - base), 64'd6);
      m = {32'($urandom), 32'($urandom)};
      finish_window(m, 1);

      // 6: only stock 0 ticks for a long stretch
      base = n_issue;
      p = 16'($urandom);
      send_tick(0, p);
`ifdef COV_SEQ_STALE_EN
      exp_q.push_back({m_slot[1], m_slot[0]});
      m_mask = '0;
      n = 0;
      while (n_issue == base && n < 40) begin
         step();
         n++;
      end
      check("stale_issue", 64'(n_issue - base), 64'd1);
`else
      repeat (40) step();
      check("no_stale_issue", 64'(n_issue - base), 64'd0);
      check("still_gather", 64'(tick_ready), 64'd1);
      send_tick(1, 16'($urandom));
      check("late_issue", 64'(cov_valid_in), 64'd1);
`endif

      repeat (3) step();
      check("model_drained", 64'(exp_q.size()), 64'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
